// File: rtl/cursor_ctrl_if.sv
// Keyboard, selection handshake and pixel-write signals of the board cursor controller.
// master is the controller side, slave is the keyboard/consumer/framebuffer side.
interface cursor_ctrl_if #(
  parameter int CW = 3
);
  logic          key_up;
  logic          key_down;
  logic          key_left;
  logic          key_right;
  logic          key_enter;
  logic          sel_ready;
  logic [CW-1:0] cur_col;
  logic [CW-1:0] cur_row;
  logic          sel_valid;
  logic [CW-1:0] sel_col;
  logic [CW-1:0] sel_row;
  logic [7:0]    plot_x;
  logic [6:0]    plot_y;
  logic [2:0]    plot_colour;
  logic          plot_we;
  logic          busy;

  modport master (
    input  key_up, key_down, key_left, key_right, key_enter, sel_ready,
    output cur_col, cur_row, sel_valid, sel_col, sel_row,
           plot_x, plot_y, plot_colour, plot_we, busy
  );

  modport slave (
    output key_up, key_down, key_left, key_right, key_enter, sel_ready,
    input  cur_col, cur_row, sel_valid, sel_col, sel_row,
           plot_x, plot_y, plot_colour, plot_we, busy
  );
endinterface

// File: rtl/cursor_ctrl.sv
// Board cursor controller: moves a cell cursor from decoded keys, redraws the cell
// outline through a pixel-write port and hands selections to a consumer.
module cursor_ctrl #(
  parameter int         BOARD_N   = 8,
  parameter int         CELL_PX   = 8,
  parameter bit         WRAP      = 1'b0,
  parameter int         ORIGIN_X  = 16,
  parameter int         ORIGIN_Y  = 8,
  parameter logic [2:0] CUR_COL   = 3'b110,
  parameter logic [2:0] ERASE_COL = 3'b000
) (
  input logic          clk,
  input logic          resetn,
  cursor_ctrl_if.master bus
);
  localparam int CW = (BOARD_N > 1) ? $clog2(BOARD_N) : 1;
  localparam int PW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam logic [CW-1:0] LAST_CELL = CW'(BOARD_N - 1);
  localparam logic [PW-1:0] LAST_PX   = PW'(CELL_PX - 1);

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_IDLE     = 3'd1,
    S_ERASE    = 3'd2,
    S_DRAW     = 3'd3,
    S_SEL      = 3'd4,
    S_WAIT_REL = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] curCol, curRow, prevCol, prevRow, selCol, selRow;
  logic          selValid;
  logic [PW-1:0] px_p0, py_p0;
  logic [7:0]    plotX_p1;
  logic [6:0]    plotY_p1;
  logic [2:0]    plotCol_p1;
  logic          vld_p1;

  logic          anyKey, moveReq, moveOk, drawing, lastPx;
  logic [CW-1:0] nxtCol, nxtRow, phaseCol, phaseRow;
  logic [2:0]    phaseColour;

  function automatic logic [7:0] pixX(input logic [CW-1:0] c, input logic [PW-1:0] p);
    int v;
    v = ORIGIN_X + int'(c) * CELL_PX + int'(p);
    return 8'(v);
  endfunction

  function automatic logic [6:0] pixY(input logic [CW-1:0] r, input logic [PW-1:0] p);
    int v;
    v = ORIGIN_Y + int'(r) * CELL_PX + int'(p);
    return 7'(v);
  endfunction

  function automatic logic isBorder(input logic [PW-1:0] x, input logic [PW-1:0] y);
    return (x == '0) || (x == LAST_PX) || (y == '0) || (y == LAST_PX);
  endfunction

  assign anyKey = bus.key_up | bus.key_down | bus.key_left | bus.key_right | bus.key_enter;
  assign drawing = (state == S_INIT) || (state == S_ERASE) || (state == S_DRAW);
  assign lastPx = (px_p0 == LAST_PX) && (py_p0 == LAST_PX);
  assign phaseCol = (state == S_ERASE) ? prevCol : curCol;
  assign phaseRow = (state == S_ERASE) ? prevRow : curRow;
  assign phaseColour = (state == S_ERASE) ? ERASE_COL : CUR_COL;

  // Key priority: enter, up, down, left, right; an edge move is blocked unless WRAP.
  always_comb begin
    moveReq = 1'b0;
    moveOk  = 1'b0;
    nxtCol  = curCol;
    nxtRow  = curRow;
    if (bus.key_enter) begin
      moveReq = 1'b0;
    end else if (bus.key_up) begin
      moveReq = 1'b1;
      if (curRow != '0) begin nxtRow = curRow - 1'b1; moveOk = 1'b1; end
      else if (WRAP)    begin nxtRow = LAST_CELL;     moveOk = 1'b1; end
    end else if (bus.key_down) begin
      moveReq = 1'b1;
      if (curRow != LAST_CELL) begin nxtRow = curRow + 1'b1; moveOk = 1'b1; end
      else if (WRAP)           begin nxtRow = '0;            moveOk = 1'b1; end
    end else if (bus.key_left) begin
      moveReq = 1'b1;
      if (curCol != '0) begin nxtCol = curCol - 1'b1; moveOk = 1'b1; end
      else if (WRAP)    begin nxtCol = LAST_CELL;     moveOk = 1'b1; end
    end else if (bus.key_right) begin
      moveReq = 1'b1;
      if (curCol != LAST_CELL) begin nxtCol = curCol + 1'b1; moveOk = 1'b1; end
      else if (WRAP)           begin nxtCol = '0;            moveOk = 1'b1; end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_INIT;
      px_p0      <= '0;
      py_p0      <= '0;
      curCol     <= '0;
      curRow     <= '0;
      prevCol    <= '0;
      prevRow    <= '0;
      selValid   <= 1'b0;
      selCol     <= '0;
      selRow     <= '0;
      vld_p1     <= 1'b0;
      plotX_p1   <= '0;
      plotY_p1   <= '0;
      plotCol_p1 <= '0;
    end else begin
      // Stage p0 -> p1: the pixel counter drives the registered write port one cycle later.
      if (drawing) begin
        vld_p1     <= isBorder(px_p0, py_p0);
        plotX_p1   <= pixX(phaseCol, px_p0);
        plotY_p1   <= pixY(phaseRow, py_p0);
        plotCol_p1 <= phaseColour;
        if (px_p0 == LAST_PX) begin
          px_p0 <= '0;
          py_p0 <= py_p0 + 1'b1;
        end else begin
          px_p0 <= px_p0 + 1'b1;
        end
      end else begin
        vld_p1 <= 1'b0;
      end

      case (state)
        S_INIT: if (lastPx) state <= S_IDLE;
        S_IDLE: begin
          if (bus.key_enter) begin
            selValid <= 1'b1;
            selCol   <= curCol;
            selRow   <= curRow;
            state    <= S_SEL;
          end else if (moveReq) begin
            if (moveOk) begin
              prevCol <= curCol;
              prevRow <= curRow;
              curCol  <= nxtCol;
              curRow  <= nxtRow;
              px_p0   <= '0;
              py_p0   <= '0;
              state   <= S_ERASE;
            end else begin
              state <= S_WAIT_REL;
            end
          end
        end
        S_ERASE: begin
          if (lastPx) begin
            px_p0 <= '0;
            py_p0 <= '0;
            state <= S_DRAW;
          end
        end
        S_DRAW: if (lastPx) state <= S_WAIT_REL;
        S_SEL: begin
          if (bus.sel_ready) begin
            selValid <= 1'b0;
            state    <= S_WAIT_REL;
          end
        end
        S_WAIT_REL: if (!anyKey) state <= S_IDLE;
        default: begin
          px_p0 <= '0;
          py_p0 <= '0;
          state <= S_INIT;
        end
      endcase
    end
  end

  assign bus.cur_col     = curCol;
  assign bus.cur_row     = curRow;
  assign bus.sel_valid   = selValid;
  assign bus.sel_col     = selCol;
  assign bus.sel_row     = selRow;
  assign bus.plot_x      = plotX_p1;
  assign bus.plot_y      = plotY_p1;
  assign bus.plot_colour = plotCol_p1;
  assign bus.plot_we     = vld_p1;
  assign bus.busy        = (state != S_IDLE);
endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed bench for cursor_ctrl: a clamping instance and a wrapping instance share
// the clock, reset and key stimulus; pixel writes are tallied per cycle.
module tb_cursor_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cursor_ctrl_if #(.CW(3)) b0 ();
  cursor_ctrl_if #(.CW(3)) b1 ();

  cursor_ctrl #(.WRAP(1'b0)) dut0 (.clk(clk), .resetn(resetn), .bus(b0));
  cursor_ctrl #(.WRAP(1'b1)) dut1 (.clk(clk), .resetn(resetn), .bus(b1));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int eCnt, dCnt, oCnt, lastE, firstD;
  int eMinX, eMaxX, eMinY, eMaxY, dMinX, dMaxX, dMinY, dMaxY;
  int e1Cnt, d1Cnt, d1MinY, d1MaxY;
  int n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    eCnt = 0; dCnt = 0; oCnt = 0; lastE = 0; firstD = 0;
    eMinX = 9999; eMaxX = -1; eMinY = 9999; eMaxY = -1;
    dMinX = 9999; dMaxX = -1; dMinY = 9999; dMaxY = -1;
    e1Cnt = 0; d1Cnt = 0; d1MinY = 9999; d1MaxY = -1;
  endtask

  task automatic keys(input logic u, input logic d, input logic l, input logic r, input logic e);
    b0.key_up = u; b0.key_down = d; b0.key_left = l; b0.key_right = r; b0.key_enter = e;
    b1.key_up = u; b1.key_down = d; b1.key_left = l; b1.key_right = r; b1.key_enter = e;
  endtask

  task automatic ready(input logic v);
    b0.sel_ready = v;
    b1.sel_ready = v;
  endtask

  task automatic tick();
    int x, y;
    @(posedge clk);
    #1;
    cyc++;
    x = int'(b0.plot_x);
    y = int'(b0.plot_y);
    if (b0.plot_we === 1'b1) begin
      if (b0.plot_colour === 3'b000) begin
        eCnt++; lastE = cyc;
        if (x < eMinX) eMinX = x;
        if (x > eMaxX) eMaxX = x;
        if (y < eMinY) eMinY = y;
        if (y > eMaxY) eMaxY = y;
      end else if (b0.plot_colour === 3'b110) begin
        if (dCnt == 0) firstD = cyc;
        dCnt++;
        if (x < dMinX) dMinX = x;
        if (x > dMaxX) dMaxX = x;
        if (y < dMinY) dMinY = y;
        if (y > dMaxY) dMaxY = y;
      end else begin
        oCnt++;
      end
    end
    if (b1.plot_we === 1'b1) begin
      y = int'(b1.plot_y);
      if (b1.plot_colour === 3'b000) e1Cnt++;
      else if (b1.plot_colour === 3'b110) begin
        d1Cnt++;
        if (y < d1MinY) d1MinY = y;
        if (y > d1MaxY) d1MaxY = y;
      end
    end
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic waitIdle(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (b0.busy !== 1'b0 && cnt < 300);
  endtask

  initial begin
    clr();
    keys(0, 0, 0, 0, 0);
    ready(1'b0);
    resetn = 1'b0;
    ticks(3);
    chk("rst_plot_we", 32'(b0.plot_we), 0);
    chk("rst_plot_x", 32'(b0.plot_x), 0);
    chk("rst_plot_y", 32'(b0.plot_y), 0);
    chk("rst_plot_colour", 32'(b0.plot_colour), 0);
    chk("rst_cur_col", 32'(b0.cur_col), 0);
    chk("rst_cur_row", 32'(b0.cur_row), 0);
    chk("rst_sel_valid", 32'(b0.sel_valid), 0);
    chk("rst_busy", 32'(b0.busy), 1);

    // Power-up draw of the cursor at (0,0).
    resetn = 1'b1;
    clr();
    waitIdle(n);
    chk("init_cycles", n, 64);
    chk("init_draw_cnt", dCnt, 28);
    chk("init_erase_cnt", eCnt, 0);
    chk("init_other_cnt", oCnt, 0);
    chk("init_x_min", dMinX, 16);
    chk("init_x_max", dMaxX, 23);
    chk("init_y_min", dMinY, 8);
    chk("init_y_max", dMaxY, 15);
    chk("init_wrap_busy", 32'(b1.busy), 0);
    chk("init_wrap_draw_cnt", d1Cnt, 28);

    // Up from row 0: clamp vs wrap.
    clr();
    keys(1, 0, 0, 0, 0);
    ticks(5);
    keys(0, 0, 0, 0, 0);
    ticks(140);
    chk("clamp_up_row", 32'(b0.cur_row), 0);
    chk("clamp_up_col", 32'(b0.cur_col), 0);
    chk("clamp_up_writes", eCnt + dCnt + oCnt, 0);
    chk("clamp_up_busy", 32'(b0.busy), 0);
    chk("wrap_up_row", 32'(b1.cur_row), 7);
    chk("wrap_up_col", 32'(b1.cur_col), 0);
    chk("wrap_up_erase_cnt", e1Cnt, 28);
    chk("wrap_up_draw_cnt", d1Cnt, 28);
    chk("wrap_up_y_min", d1MinY, 64);
    chk("wrap_up_y_max", d1MaxY, 71);

    // Left from column 0 clamps.
    clr();
    keys(0, 0, 1, 0, 0);
    ticks(5);
    keys(0, 0, 0, 0, 0);
    ticks(5);
    chk("clamp_left_col", 32'(b0.cur_col), 0);
    chk("clamp_left_writes", eCnt + dCnt + oCnt, 0);

    // Held right key: exactly one move to (1,0).
    clr();
    keys(0, 0, 0, 1, 0);
    ticks(200);
    keys(0, 0, 0, 0, 0);
    ticks(5);
    chk("right_col", 32'(b0.cur_col), 1);
    chk("right_row", 32'(b0.cur_row), 0);
    chk("right_erase_cnt", eCnt, 28);
    chk("right_draw_cnt", dCnt, 28);
    chk("right_other_cnt", oCnt, 0);
    chk("right_erase_x_min", eMinX, 16);
    chk("right_erase_x_max", eMaxX, 23);
    chk("right_draw_x_min", dMinX, 24);
    chk("right_draw_x_max", dMaxX, 31);
    chk("right_draw_y_min", dMinY, 8);
    chk("right_order", 32'(lastE < firstD), 1);

    // Down to (1,1).
    clr();
    keys(0, 1, 0, 0, 0);
    ticks(150);
    keys(0, 0, 0, 0, 0);
    ticks(5);
    chk("down_row", 32'(b0.cur_row), 1);
    chk("down_col", 32'(b0.cur_col), 1);
    chk("down_erase_y_min", eMinY, 8);
    chk("down_draw_cnt", dCnt, 28);
    chk("down_draw_y_min", dMinY, 16);
    chk("down_draw_y_max", dMaxY, 23);
    chk("down_draw_x_min", dMinX, 24);

    // Selection held off by sel_ready low.
    keys(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("sel_valid_hold", 32'(b0.sel_valid), 1);
      chk("sel_col_hold", 32'(b0.sel_col), 1);
      chk("sel_row_hold", 32'(b0.sel_row), 1);
    end
    ready(1'b1);
    tick();
    chk("sel_valid_drop", 32'(b0.sel_valid), 0);
    chk("sel_wait_busy", 32'(b0.busy), 1);
    keys(0, 0, 0, 0, 0);
    ready(1'b0);
    ticks(2);
    chk("sel_idle_busy", 32'(b0.busy), 0);

    // Enter beats left in the same cycle.
    clr();
    keys(0, 0, 1, 0, 1);
    tick();
    chk("prio_sel_valid", 32'(b0.sel_valid), 1);
    chk("prio_cur_col", 32'(b0.cur_col), 1);
    ready(1'b1);
    tick();
    chk("prio_sel_drop", 32'(b0.sel_valid), 0);
    keys(0, 0, 0, 0, 0);
    ready(1'b0);
    ticks(3);
    chk("prio_final_col", 32'(b0.cur_col), 1);
    chk("prio_writes", eCnt + dCnt + oCnt, 0);

    // Reset in the middle of an erase.
    keys(0, 0, 0, 1, 0);
    tick();
    chk("abort_moved_col", 32'(b0.cur_col), 2);
    keys(0, 0, 0, 0, 0);
    ticks(10);
    resetn = 1'b0;
    tick();
    chk("abort_plot_we", 32'(b0.plot_we), 0);
    chk("abort_cur_col", 32'(b0.cur_col), 0);
    chk("abort_cur_row", 32'(b0.cur_row), 0);
    chk("abort_busy", 32'(b0.busy), 1);
    resetn = 1'b1;
    clr();
    waitIdle(n);
    chk("reinit_cycles", n, 64);
    chk("reinit_draw_cnt", dCnt, 28);
    chk("reinit_erase_cnt", eCnt, 0);
    chk("reinit_x_min", dMinX, 16);
    chk("reinit_y_max", dMaxY, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cursor_ctrl.md
CURSOR_CTRL -- requirements
Module: cursor_ctrl

Interface
REQ-001 Parameter BOARD_N, default 8: board cells per side; CW = clog2(BOARD_N).
REQ-002 Parameter CELL_PX, default 8: cell edge length in pixels; PW = clog2(CELL_PX).
REQ-003 Parameter WRAP, default 0: 1 = cursor wraps at board edges; 0 = cursor clamps at board edges.
REQ-004 Parameters ORIGIN_X, default 16, and ORIGIN_Y, default 8: screen pixel of the top-left corner of cell (0,0).
REQ-005 Parameters CUR_COL, default 3'b110, and ERASE_COL, default 3'b000: cursor colour and erase colour.
REQ-006 clk  in  1  clock; all state changes on the rising edge.
REQ-007 resetn  in  1  reset, synchronous, active-low.
REQ-008 key_up, key_down, key_left, key_right, key_enter  in  1 each  level-high decoded keyboard keys.
REQ-009 sel_ready  in  1  consumer accepts the current selection.
REQ-010 cur_col, cur_row  out  CW each  registered cursor position.
REQ-011 sel_valid  out  1  selection request; sel_col, sel_row  out  CW each  selected cell.
REQ-012 plot_x  out  8, plot_y  out  7, plot_colour  out  3, plot_we  out  1  registered pixel-write port.
REQ-013 busy  out  1  high in every state except S_IDLE.

Function
REQ-014 The FSM SHALL have states S_INIT, S_IDLE, S_ERASE, S_DRAW, S_SEL, S_WAIT_REL.
REQ-015 S_INIT SHALL walk the pixel counter over the cursor cell, then go to S_IDLE; it draws the same pixels as S_DRAW.
REQ-016 In S_IDLE, key_enter SHALL take priority, followed by key_up, key_down, key_left and key_right; only one action is taken per sample.
REQ-017 For a move, the FSM SHALL latch the old position into prev_col/prev_row, update the cursor on the same edge, and enter S_ERASE.
REQ-018 Up SHALL decrement the row and left SHALL decrement the column; down and right SHALL increment them.
REQ-019 With WRAP=1, the cursor SHALL wrap 0 <-> BOARD_N-1.
REQ-020 With WRAP=0, a move past an edge SHALL leave the cursor unchanged, produce no pixel writes, and go directly to S_WAIT_REL.
REQ-021 S_ERASE SHALL walk the pixel counter (px, py) over CELL_PX*CELL_PX cycles for prev_col/prev_row using ERASE_COL, then go to S_DRAW.
REQ-022 S_DRAW SHALL do the same for cur_col/cur_row using CUR_COL, then go to S_WAIT_REL.
REQ-023 The pixel counter SHALL step px fastest and py slowest, and SHALL reset to 0 on entry to each drawing state.
REQ-024 plot_we SHALL be asserted only for border pixels (px or py equal to 0 or CELL_PX-1), i.e. 4*CELL_PX-4 writes per phase.
REQ-025 All plot outputs SHALL lag their counter value by exactly one cycle.
REQ-026 plot_x SHALL equal ORIGIN_X + col*CELL_PX + px, and plot_y SHALL equal ORIGIN_Y + row*CELL_PX + py, truncated to port width.
REQ-027 On enter, the FSM SHALL go to S_SEL, assert sel_valid, and hold sel_col/sel_row equal to the cursor.
REQ-028 sel_valid SHALL remain high until sel_ready is sampled high; sel_valid then drops on the next edge and the FSM goes to S_WAIT_REL.
REQ-029 S_WAIT_REL SHALL remain until all five keys are low, then go to S_IDLE, so that one press produces one action.
REQ-030 Keys SHALL be ignored in S_INIT, S_ERASE, S_DRAW and S_SEL.
REQ-031 Illegal state encodings SHALL transition to S_INIT.

Reset
REQ-032 While resetn is low at a clock edge, the block SHALL set state S_INIT, counter 0, cursor (0,0), prev (0,0), sel_valid 0, plot_we 0, plot_x 0, plot_y 0 and plot_colour 0.
REQ-033 Reset asserted mid-draw or mid-handshake SHALL abort that operation; no further writes from it occur, and S_INIT redraws the cursor at (0,0).

Verification
REQ-034 Release reset with defaults -> 28 plot_we pulses at x 16..23, y 8..15 with colour 3'b110, then busy falls after 64 counter cycles.
REQ-035 In S_IDLE, hold key_right for 200 cycles -> cursor (1,0); 28 erase writes at x 16..23 with colour 0, then 28 draw writes at x 24..31; one move only.
REQ-036 WRAP=0 with the cursor at (0,0), press key_up -> cursor stays (0,0), no plot_we; WRAP=1, press key_up -> cursor (0,7), with draw writes at y 64..71.
REQ-037 Press key_enter with sel_ready low for 10 cycles -> sel_valid high for all 10 cycles with sel_col=cur_col and sel_row=cur_row; raise sel_ready -> sel_valid low on the next edge.
REQ-038 Press key_left and key_enter in the same cycle -> selection taken and cursor unchanged; assert resetn=0 mid-S_ERASE -> plot_we 0 next cycle and cursor returns to (0,0).
